// File: rtl/multitap_echo_pkg.sv
// Shared types and helpers for the multi-tap echo.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multitap_echo_pkg;

    // Defaults kept in step with music_player's PCM path.
    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACC  = 2'd2,
        WR   = 2'd3
    } state_e;

    // Clamp a signed value to the range of a w-bit signed number.
    // Callers truncate the result to w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      saturate = hi;
        else if (v < lo) saturate = lo;
        else             saturate = v;
    endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous sample history RAM, DEPTH x WIDTH, write-first.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts one access per cycle.
// Ports: clk_i clock; we_i write enable; addr_i address; wdata_i write data;
//        rdata_o registered read data (returns wdata_i on a write cycle).
module echo_ram #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset so this maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
            rdata_o     <= wdata_i;
        end else begin
            rdata_o     <= mem[addr_i];
        end
    end

endmodule

// File: rtl/multitap_echo.sv
// N-tap echo on the mono PCM stream, one tap read per cycle from a single-port history RAM.
// Latency: out_valid pulses 2*NUM_TAPS+2 cycles after the new_frame cycle.
// Backpressure: none; a new_frame arriving while busy is dropped and latches overrun.
// Ports: clk, reset_n (async, active low); new_frame strobe with sample_in, echo_en,
//        delay_base inputs; sample_out/out_valid result; busy and sticky overrun status.
// Build option: define MULTITAP_ECHO_FEEDBACK_EN to store the wet output in the history
//        (recirculating IIR echo); otherwise the dry input is stored (FIR echo).
module multitap_echo
    import multitap_echo_pkg::*;
#(
    parameter  int WIDTH       = DEFAULT_WIDTH,
    parameter  int DEPTH       = DEFAULT_DEPTH,
    parameter  int NUM_TAPS    = 3,
    parameter  int ATTEN_SHIFT = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    new_frame,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    echo_en,
    input  logic [AW-1:0]           delay_base,
    output logic signed [WIDTH-1:0] sample_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ACCW = WIDTH + 4;
    // Offset is wide enough to hold NUM_TAPS*delay_base without wrapping, so
    // taps reaching past the history can be detected and suppressed.
    localparam int OW   = AW + 4;
    localparam int KW   = 4;

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q;
    logic [OW-1:0]            off_q;
    logic [AW-1:0]            wp_q, fill_q, dbase_q;
    logic signed [WIDTH-1:0]  dry_q, sample_out_q;
    logic signed [ACCW-1:0]   acc_q;
    logic                     out_valid_q, overrun_q;

    logic                     ram_we;
    logic [AW-1:0]            ram_addr;
    logic [WIDTH-1:0]         ram_wdata, ram_rdata;

    logic                     tap_live;
    logic [7:0]               shamt;
    logic signed [ACCW-1:0]   tap_ext, tap_val;
    logic signed [WIDTH-1:0]  wet;

    echo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (new_frame) state_d = RD;
            RD:      state_d = ACC;
            ACC:     state_d = (k_q == KW'(NUM_TAPS)) ? WR : RD;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: RAM sequencing and busy
    always_comb begin
        busy     = (state_q != IDLE);
        ram_we   = (state_q == WR);
        ram_addr = (state_q == WR) ? wp_q : (wp_q - off_q[AW-1:0]);
    end

    // A tap only counts if its delay lies inside history written since reset
    // and inside the RAM itself; otherwise it contributes nothing.
    assign tap_live = echo_en && (dbase_q != '0) &&
                      (off_q <= OW'(fill_q)) && (off_q <= OW'(DEPTH - 1));
    assign shamt    = 8'(k_q) * 8'(ATTEN_SHIFT);
    assign tap_ext  = ACCW'($signed(ram_rdata));
    assign tap_val  = tap_ext >>> shamt;
    assign wet      = WIDTH'(saturate(64'(acc_q), WIDTH));

`ifdef MULTITAP_ECHO_FEEDBACK_EN
    assign ram_wdata = wet;
`else
    assign ram_wdata = dry_q;
`endif

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q          <= '0;
            off_q        <= '0;
            wp_q         <= '0;
            fill_q       <= '0;
            dbase_q      <= '0;
            dry_q        <= '0;
            acc_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (new_frame && (state_q != IDLE)) overrun_q <= 1'b1;
            unique case (state_q)
                IDLE: if (new_frame) begin
                    dry_q   <= sample_in;
                    dbase_q <= delay_base;
                    acc_q   <= ACCW'(sample_in);
                    k_q     <= KW'(1);
                    off_q   <= OW'(delay_base);
                end
                ACC: begin
                    if (tap_live) acc_q <= acc_q + tap_val;
                    if (k_q != KW'(NUM_TAPS)) begin
                        k_q   <= k_q + KW'(1);
                        off_q <= off_q + OW'(dbase_q);
                    end
                end
                WR: begin
                    wp_q         <= wp_q + AW'(1);
                    if (fill_q != AW'(DEPTH - 1)) fill_q <= fill_q + AW'(1);
                    sample_out_q <= wet;
                    out_valid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_multitap_echo.sv
module tb_multitap_echo;

    localparam int W     = 16;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int SH    = 1;
`ifdef MULTITAP_ECHO_FEEDBACK_EN
    localparam int NT    = 1;
`else
    localparam int NT    = 3;
`endif
    localparam int LAT   = 2 * NT + 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                new_frame = 1'b0;
    logic signed [W-1:0] sample_in = '0;
    logic                echo_en = 1'b0;
    logic [AW-1:0]       delay_base = '0;
    logic signed [W-1:0] sample_out;
    logic                out_valid, busy, overrun;

    multitap_echo #(.WIDTH(W), .DEPTH(DEPTH), .NUM_TAPS(NT), .ATTEN_SHIFT(SH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .new_frame  (new_frame),
        .sample_in  (sample_in),
        .echo_en    (echo_en),
        .delay_base (delay_base),
        .sample_out (sample_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hist[$];          // stored history word per accepted frame
    int nframes = 0;
    logic signed [W-1:0] last_out;

    function automatic void model_reset();
        hist.delete();
        nframes = 0;
    endfunction

    // Frame-indexed reference: frame n sees history of frames n-d.
    function automatic int model_step(int x, bit en, int db);
        int fill, acc, d, wet;
        fill = (nframes < DEPTH - 1) ? nframes : DEPTH - 1;
        acc  = x;
        for (int k = 1; k <= NT; k++) begin
            d = k * db;
            if (en && db != 0 && d <= fill && d <= DEPTH - 1)
                acc += hist[nframes - d] >>> (k * SH);
        end
        wet = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
`ifdef MULTITAP_ECHO_FEEDBACK_EN
        hist.push_back(wet);
`else
        hist.push_back(x);
`endif
        nframes++;
        return wet;
    endfunction

    task automatic apply_reset();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        model_reset();
    endtask

    task automatic do_frame(input logic signed [W-1:0] x, input bit en, input int db);
        int  exp_v, lat;
        bit  seen;
        exp_v = model_step(int'(x), en, db);
        @(negedge clk);
        sample_in = x; echo_en = en; delay_base = AW'(db); new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        lat = 1; seen = 0;
        while (!seen && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1;
        end
        n_checks++;
        if (!seen || lat != LAT) begin
            n_fail++;
            $display("FAIL latency frame %0d: got %0d cycles (seen=%0d), want %0d", nframes - 1, lat, seen, LAT);
        end
        n_checks++;
        if (sample_out !== W'(exp_v)) begin
            n_fail++;
            $display("FAIL model frame %0d: sample_out=%h want %h", nframes - 1, sample_out, W'(exp_v));
        end
        last_out = sample_out;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({sample_out, out_valid, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: out=%h vld=%b busy=%b ovr=%b, want all 0", sample_out, out_valid, busy, overrun);
        end
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        do_frame(16'sh1234, 1'b1, 4);
        // start a frame and reset it from the middle of the ACC phase
        @(negedge clk);
        sample_in = 16'sh0555; new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_midframe: busy=%b want 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sample_out, out_valid, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: out=%h vld=%b busy=%b ovr=%b, want all 0", sample_out, out_valid, busy, overrun);
        end
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        do_frame(16'sh2468, 1'b1, 4);
    endtask

    task automatic test_fir_impulse();
        int ev;
        apply_reset();
        for (int f = 0; f <= 16; f++) begin
            do_frame((f == 0) ? 16'sh4000 : 16'sh0000, 1'b1, 4);
`ifndef MULTITAP_ECHO_FEEDBACK_EN
            ev = (f == 0) ? 'h4000 : (f == 4) ? 'h2000 : (f == 8) ? 'h1000 : (f == 12) ? 'h0800 : 0;
            n_checks++;
            if (last_out !== W'(ev)) begin
                n_fail++;
                $display("FAIL fir_impulse frame %0d: got %h want %h", f, last_out, W'(ev));
            end
`endif
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int f = 0; f < 8; f++) begin
            do_frame(16'sh7000, 1'b1, 1);
            if (f >= 1) begin
                n_checks++;
                if (last_out !== 16'sh7FFF) begin
                    n_fail++;
                    $display("FAIL sat_pos frame %0d: got %h want 7fff", f, last_out);
                end
            end
        end
        apply_reset();
        for (int f = 0; f < 8; f++) begin
            do_frame(16'sh9000, 1'b1, 1);
            if (f >= 1) begin
                n_checks++;
                if (last_out !== 16'sh8000) begin
                    n_fail++;
                    $display("FAIL sat_neg frame %0d: got %h want 8000", f, last_out);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int f = 0; f < 150; f++) begin
            do_frame(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 12));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic test_bypass();
        logic signed [W-1:0] x;
        for (int f = 0; f < 20; f++) begin
            x = W'($urandom);
            do_frame(x, 1'b0, $urandom_range(1, 6));
            n_checks++;
            if (last_out !== x) begin
                n_fail++;
                $display("FAIL bypass frame %0d: got %h want %h", f, last_out, x);
            end
        end
    endtask

    task automatic test_overrun();
        int  exp_v, lat;
        bit  seen;
        apply_reset();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        exp_v = model_step('h0321, 1'b1, 3);
        @(negedge clk);
        sample_in = 16'sh0321; echo_en = 1'b1; delay_base = AW'(3); new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        lat = 1; seen = 0;
        while (!seen && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            new_frame = (lat == 3);
            sample_in = (lat == 3) ? 16'sh7777 : 16'sh0321;
            if (lat == 4) begin
                n_checks++;
                if (overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_set: got %b want 1", overrun);
                end
            end
            if (out_valid) seen = 1;
        end
        new_frame = 1'b0;
        n_checks++;
        if (!seen || lat != LAT) begin
            n_fail++;
            $display("FAIL overrun_latency: got %0d (seen=%0d) want %0d", lat, seen, LAT);
        end
        n_checks++;
        if (sample_out !== W'(exp_v)) begin
            n_fail++;
            $display("FAIL overrun_first_frame: got %h want %h", sample_out, W'(exp_v));
        end
        // dropped frame must leave no trace in the following outputs
        for (int f = 0; f < 6; f++) do_frame(W'($urandom), 1'b1, 1);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
    endtask

    task automatic test_wrap();
        logic signed [W-1:0] x;
        int ev;
        apply_reset();
        for (int n = 0; n <= 4110; n++) begin
            x = (n == 0 || n == 100) ? 16'sh4000 : (n == 3000) ? 16'sh2000 : 16'sh0000;
            do_frame(x, 1'b1, 2000);
`ifndef MULTITAP_ECHO_FEEDBACK_EN
            if (n == 2000 || n == 2100 || n == 4000 || n == 4100) begin
                ev = (n < 4000) ? 'h2000 : 'h1000;
                n_checks++;
                if (last_out !== W'(ev)) begin
                    n_fail++;
                    $display("FAIL wrap frame %0d: got %h want %h", n, last_out, W'(ev));
                end
            end
`endif
        end
    endtask

`ifdef MULTITAP_ECHO_FEEDBACK_EN
    task automatic test_feedback();
        int ev;
        apply_reset();
        for (int f = 0; f < 64; f++) begin
            do_frame((f == 0) ? 16'sh4000 : 16'sh0000, 1'b1, 4);
            ev = (f % 4 == 0) ? ('h4000 >> (f / 4)) : 0;
            n_checks++;
            if (last_out !== W'(ev)) begin
                n_fail++;
                $display("FAIL feedback frame %0d: got %h want %h", f, last_out, W'(ev));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fir_impulse();
        test_saturation();
        test_random();
        test_bypass();
        test_overrun();
`ifdef MULTITAP_ECHO_FEEDBACK_EN
        test_feedback();
`endif
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multitap_echo.md
Name: multitap_echo

Overview:
- Parametrised successor to the single-tap echo in music_player: N-tap echo/delay on the mono PCM stream, runtime-programmable tap spacing.
- Sits between the note/harmonics mixer output and the ac97_if PCM_Playback inputs.
- Advances one sample per new_frame strobe, i.e. per codec PCM_Playback_Accept.
- Single-port sample history RAM, sequenced one tap per cycle by a small FSM.

Parameters:
- WIDTH, 16, signed sample width.
- DEPTH, 4096, history RAM entries; power of two; AW = $clog2(DEPTH).
- NUM_TAPS, 3, echo taps, 1..8.
- ATTEN_SHIFT, 1, tap k (1-based) is scaled by 2^-(k*ATTEN_SHIFT) via arithmetic right shift.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- new_frame  in  1  one-cycle strobe; a new sample is due.
- sample_in  in  WIDTH  signed dry sample; sampled on the new_frame cycle.
- echo_en  in  1  1 = add echo taps; 0 = dry passthrough.
- delay_base  in  AW  tap spacing in frames; tap k delay = k*delay_base.
- sample_out  out  WIDTH  signed wet/dry result; held between updates.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  FSM not in IDLE.
- overrun  out  1  sticky; set when new_frame arrives while busy. Cleared only by reset.

Behaviour:
- Reset (async, reset_n low) clears: sample_out=0, out_valid=0, busy=0, overrun=0, write pointer wp=0, fill counter=0, accumulator=0, FSM=IDLE. RAM contents are not reset.
- Clock-enable rule: registers update only on clk rising edge when reset_n is high.
- FSM states and transitions:
  - IDLE: on new_frame, capture sample_in and delay_base into regs; acc = sign-extended sample_in; k=1; go to RD.
  - RD: issue RAM read at wp - k*delay_base (mod DEPTH; k*delay_base built by repeated addition, no multiplier); go to ACC.
  - ACC: RAM data valid (1-cycle read latency); if tap k is live, acc += data >>> (k*ATTEN_SHIFT); if k==NUM_TAPS go to WR, else k++ and go to RD.
  - WR: write the history word at wp; wp++ (wraps at DEPTH); fill = min(fill+1, DEPTH-1); sample_out = sat(acc); out_valid=1; go to IDLE.
- Tap k is live iff all of: echo_en=1, delay_base!=0, k*delay_base <= fill, k*delay_base <= DEPTH-1. Dead taps add 0 and still take their cycles.
- Fill gating means unwritten RAM never reaches the output after reset.
- Latency: out_valid asserts exactly 2*NUM_TAPS+2 cycles after the new_frame cycle (8 cycles for the default NUM_TAPS=3).
- Accumulator width WIDTH+4. sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- echo_en=0: sample_out = sample_in after the same latency; history is still written, so enabling echo is seamless.
- new_frame while busy: that frame is dropped; overrun set; the FSM finishes the current frame unaffected.
- delay_base changes take effect only at the next frame's capture in IDLE.
- wp wrap-around: address arithmetic is modulo DEPTH.

Optional Feature:
- Macro: MULTITAP_ECHO_FEEDBACK_EN.
- Defined: WR stores sat(acc), the wet output, giving recirculating decaying echo (IIR).
- Undefined: WR stores the captured dry sample_in (FIR); echoes end after NUM_TAPS repeats.
- Port list, latency and FSM are identical in both builds.

Decomposition:
- Package multitap_echo_pkg holds:
  - FSM state enum {IDLE, RD, ACC, WR};
  - saturate function, parametrised by width;
  - default WIDTH/DEPTH constants shared with music_player.
- Sub-module echo_ram: single-port synchronous RAM, DEPTH x WIDTH, 1-cycle read latency, write-first. Kept separate so it can be swapped for BRAM.

Test Plan:
1. Reset: hold reset_n low mid-frame (FSM in ACC) -> all outputs 0 immediately, asynchronously; after release and the first new_frame, out_valid comes 8 cycles later.
2. FIR impulse (feature off): delay_base=4, echo_en=1, sample_in=16'h4000 at frame 0, then 0 -> sample_out: frame0 4000, frame4 2000, frame8 1000, frame12 0800, all other frames 0.
3. Saturation: delay_base=1, constant sample_in=16'h7000 -> outputs clamp at 16'h7FFF. Repeat with 16'h9000 -> 16'h8000.
4. Fill gating and wrap: delay_base=2000 with NUM_TAPS=3 -> tap 3 (delay 6000 > DEPTH-1) never contributes. Run more than 4096 frames -> wp wraps cleanly and tap 2 still echoes at exactly 4000 frames.
5. Overrun and bypass:
   - new_frame pulses 3 cycles apart -> second frame dropped, overrun=1 and sticky.
   - echo_en=0 -> sample_out equals sample_in, latency 8 cycles.
6. Feedback build (MULTITAP_ECHO_FEEDBACK_EN, NUM_TAPS=1): delay_base=4, impulse 16'h4000 -> frames 4, 8, 12 output 2000, 1000, 0800, continuing to halve until 0.
